imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_if.sv | 36 +++
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// word-packing constants.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned DEFAULT_ADDR_W = 5;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte-stream, control and IM write-port signals of the loader.
// The slave modport is the loader itself; master is the host/IM side.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned WORD_W = 32
) ();

    logic              start_i;
    logic [ADDR_W:0]   len_i;
    logic              abort_i;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              im_we_o;
    logic [ADDR_W-1:0] im_addr_o;
    logic [WORD_W-1:0] im_wdata_o;
    logic              cpu_hold_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport slave (
        input  start_i, len_i, abort_i, byte_i, byte_valid_i,
        output byte_ready_o, im_we_o, im_addr_o, im_wdata_o,
               cpu_hold_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, len_i, abort_i, byte_i, byte_valid_i,
        input  byte_ready_o, im_we_o, im_addr_o, im_wdata_o,
               cpu_hold_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/imem_loader.sv
// Receives a big-endian byte stream, packs it into instruction words and
// writes them sequentially into the IM while holding the CPU stalled.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned WORD_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    imem_loader_if.slave bus
);

    localparam int unsigned    SHIFT_W   = WORD_W - 8;
    localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [1:0]     LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]     word_cnt_inc;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                byte_ready_q, byte_ready_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [WORD_W-1:0]   im_wdata_q, im_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;

    assign accept       = byte_ready_q && bus.byte_valid_i;
    assign word_cnt_inc = word_cnt_q + CNT_ONE;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.len_i == '0) begin
                        state_d = DONE;
                    end else if (bus.len_i > MAX_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        len_d      = bus.len_i;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        shift_d    = '0;
                        state_d    = RECV;
                    end
                end
            end
            RECV: begin
                if (accept) begin
                    shift_d    = {shift_q[SHIFT_W-9:0], bus.byte_i};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        im_addr_d  = word_cnt_q[ADDR_W-1:0];
                        im_wdata_d = {shift_q, bus.byte_i};
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_inc;
                state_d    = (word_cnt_inc == len_q) ? DONE : RECV;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.abort_i && state_q != IDLE) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
            shift_d    = '0;
        end

        // Outputs are decoded from the next state so they register in step with it.
        byte_ready_d = (state_d == RECV);
        im_we_d      = (state_d == WRITE);
        busy_d       = (state_d == RECV) || (state_d == WRITE);
        cpu_hold_d   = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            byte_ready_q <= 1'b0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= '0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            byte_ready_q <= byte_ready_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.byte_ready_o = byte_ready_q;
    assign bus.im_we_o      = im_we_q;
    assign bus.im_addr_o    = im_addr_q;
    assign bus.im_wdata_o   = im_wdata_q;
    assign bus.cpu_hold_o   = cpu_hold_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed/randomized bench for imem_loader: expected IM writes are rebuilt
// from the accepted byte stream and compared with what the loader wrote.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned WORD_W = 32;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;

    wr_t        wq[$];
    logic [7:0] bq[$];
    logic [7:0] fixed_q[$];

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; samples outputs on the falling edge and logs the IM writes.
    task automatic tick();
        @(negedge clk);
        if (bus.im_we_o === 1'b1) wq.push_back('{bus.im_addr_o, bus.im_wdata_o});
        if (bus.done_o === 1'b1) done_cnt++;
        if (bus.err_o === 1'b1) err_cnt++;
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {bus.byte_ready_o, bus.im_we_o, bus.cpu_hold_o, bus.busy_o,
                  bus.done_o, bus.err_o}, 64'h0);
    endtask

    // gap_mode: 0 back-to-back, 1 alternate valid, 2 random valid.
    task automatic run_load(input int len, input int abort_after, input int gap_mode,
                            input bit junk_start);
        int         nbytes;
        int         acc;
        int         budget;
        int         nw;
        bit         v;
        bit         rdy;
        bit         held;
        logic [7:0] cur;
        logic [WORD_W-1:0] exp_word;

        nbytes = (abort_after >= 0) ? abort_after : 4 * len;
        acc    = 0;
        v      = 1'b0;
        held   = 1'b0;
        cur    = '0;
        wq.delete();
        bq.delete();
        done_cnt = 0;

        bus.len_i   = (ADDR_W+1)'(len);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("recv_entry", {bus.busy_o, bus.cpu_hold_o, bus.byte_ready_o}, 64'h7);

        budget = 16 * nbytes + 64;
        while (acc < nbytes && budget > 0) begin
            budget--;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = ~v;
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (!held) begin
                cur  = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
                held = 1'b1;
            end
            rdy = bus.byte_ready_o;
            bus.byte_valid_i = v;
            bus.byte_i       = cur;
            if (junk_start) begin
                bus.start_i = 1'($urandom_range(0, 1));
                bus.len_i   = (ADDR_W+1)'($urandom_range(0, 40));
            end
            tick();
            if (v && rdy) begin
                bq.push_back(cur);
                acc++;
                held = 1'b0;
                if (acc % 4 == 0)
                    chk("write_strobe", {bus.im_we_o, bus.byte_ready_o}, 64'h2);
                else
                    chk("ready_held", {bus.im_we_o, bus.byte_ready_o}, 64'h1);
            end
        end
        bus.byte_valid_i = 1'b0;
        bus.start_i      = 1'b0;
        chk("bytes_accepted", 64'(acc), 64'(nbytes));

        if (abort_after >= 0) begin
            bus.abort_i = 1'b1;
            tick();
            bus.abort_i = 1'b0;
            chk_idle("abort_idle");
            repeat (3) tick();
            chk("abort_no_done", 64'(done_cnt), 64'h0);
        end else begin
            tick();
            chk("done_pulse", {bus.done_o, bus.cpu_hold_o, bus.busy_o, bus.im_we_o}, 64'hC);
            tick();
            chk_idle("release");
            chk("done_count", 64'(done_cnt), 64'h1);
        end

        nw = acc / 4;
        chk("write_count", 64'(wq.size()), 64'(nw));
        for (int k = 0; k < nw && k < wq.size(); k++) begin
            exp_word = {bq[4*k], bq[4*k+1], bq[4*k+2], bq[4*k+3]};
            chk($sformatf("addr[%0d]", k), 64'(wq[k].addr), 64'(k));
            chk($sformatf("data[%0d]", k), 64'(wq[k].data), 64'(exp_word));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start_i      = 1'b0;
        bus.len_i        = '0;
        bus.abort_i      = 1'b0;
        bus.byte_i       = '0;
        bus.byte_valid_i = 1'b0;

        #3 rst = 1'b1;
        #1 chk_idle("reset_state");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_idle("post_reset");

        // Two words from a fixed byte stream.
        fixed_q = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20};
        run_load(2, -1, 0, 1'b0);
        chk("t1_word0", 64'(wq[0].data), 64'h20010005);
        chk("t1_word1", 64'(wq[1].data), 64'h00221820);

        // Single word with byte_valid toggling.
        run_load(1, -1, 1, 1'b0);

        // Zero-length load.
        wq.delete();
        done_cnt = 0;
        bus.len_i   = '0;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("len0_done", {bus.done_o, bus.cpu_hold_o, bus.busy_o, bus.im_we_o}, 64'hC);
        tick();
        chk_idle("len0_after");
        chk("len0_writes", 64'(wq.size()), 64'h0);

        // Oversized length is rejected.
        err_cnt = 0;
        bus.len_i   = 6'd33;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("len33_err", {bus.err_o, bus.busy_o, bus.cpu_hold_o}, 64'h4);
        tick();
        chk_idle("len33_after");
        chk("len33_err_count", 64'(err_cnt), 64'h1);

        // Abort mid-load, then a fresh load overwrites address 0.
        run_load(3, 6, 0, 1'b0);
        run_load(1, -1, 2, 1'b0);

        // Asynchronous reset while receiving.
        bus.len_i   = 6'd2;
        bus.start_i = 1'b1;
        tick();
        bus.start_i      = 1'b0;
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = 8'hAA;
        tick();
        bus.byte_i = 8'hBB;
        tick();
        bus.byte_valid_i = 1'b0;
        chk("pre_reset_busy", {bus.busy_o, bus.byte_ready_o}, 64'h3);
        #2 rst = 1'b1;
        #1 chk_idle("async_reset");
        #1 rst = 1'b0;
        tick();
        chk_idle("after_async_reset");
        run_load(1, -1, 0, 1'b0);

        // Full-depth load with random gaps and ignored start pulses.
        run_load(32, -1, 2, 1'b1);
        chk("last_addr", 64'(wq[wq.size()-1].addr), 64'd31);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
